odd_parity_tx: RTL and testbench



---
 rtl/odd_parity_pkg.sv | 31 +++
 rtl/odd_parity_gen.sv | 22 ++
 rtl/odd_parity_tx.sv | 176 +++++++++++++++++
 tb/tb_odd_parity_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/odd_parity_pkg.sv
// ----------------------------------------------------------------------------
// odd_parity_pkg
// Shared definitions for the 9-bit odd-parity serial link (transmitter side
// and any receiver-side checker that recomputes parity).
//   state_e          : transmitter frame state
//   PARITY_W         : width of the parity field appended to each word
//   DEFAULT_DATA_W   : payload width of the standard link
//   FRAME_BITS       : serial bits per frame at the default payload width
//   frame_bits()     : serial bits per frame for an arbitrary payload width
// ----------------------------------------------------------------------------
package odd_parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int PARITY_W       = 1;
  localparam int DEFAULT_DATA_W = 8;

  // start + payload + parity + stop
  localparam int FRAME_BITS = DEFAULT_DATA_W + 3;

  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

endpackage : odd_parity_pkg

// File: rtl/odd_parity_gen.sv
// ----------------------------------------------------------------------------
// odd_parity_gen
// Combinational odd-parity generator. The produced bit makes the word
// {parity_out, data_in} carry an odd number of ones, so a receiver can feed
// the received payload through this same block and compare.
// Ports:
//   data_in    in   DATA_W    payload word
//   parity_out out  PARITY_W  odd-parity bit (1 when payload weight is even)
// ----------------------------------------------------------------------------
module odd_parity_gen
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   data_in,
  output logic [PARITY_W-1:0] parity_out
);

  // XNOR reduction: even payload weight -> 1, odd payload weight -> 0.
  assign parity_out = PARITY_W'(~^data_in);

endmodule : odd_parity_gen

// File: rtl/odd_parity_tx.sv
// ----------------------------------------------------------------------------
// odd_parity_tx
// Serial odd-parity transmitter. Accepts a DATA_W-bit word on a valid/ready
// handshake and sends it LSB-first as: start(0), data bits, odd parity, stop(1).
// Every serial bit is held for CLKS_PER_BIT clock cycles. All outputs are
// registered, so tx_out only changes on bit-period boundaries.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   data_in    in   DATA_W  payload word, sampled on accept
//   valid_in   in   1       data_in is valid
//   ready_out  out  1       a word can be accepted this cycle (IDLE only)
//   tx_out     out  1       serial line, idles high
//   parity_out out  1       parity of the last accepted word, held until the
//                           next accept
//   busy       out  1       a frame is in flight
// ----------------------------------------------------------------------------
module odd_parity_tx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              parity_out,
  output logic              busy
);

  // Counter widths never drop to zero, even for CLKS_PER_BIT=1 or DATA_W=1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [PARITY_W-1:0] gen_parity;
  logic [DATA_W-1:0]   shift_nxt;
  logic                accept;
  logic                bit_end;

  odd_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data_in    (data_in),
    .parity_out (gen_parity)
  );

  // ready_q is only high in IDLE, so this is the complete accept condition.
  assign accept    = valid_in && ready_q;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    busy_d   = busy_q;

    // Bit-period timer: free-runs outside IDLE, wraps at the end of each bit.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = data_in;
          parity_d = gen_parity[0];
          tx_d     = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            // Present the next bit on the line as the register shifts, so
            // tx_out always tracks the LSB of the shifted word.
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_nxt;
            tx_d    = shift_nxt[0];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          // ready rises on the edge that ends STOP; the following IDLE cycle
          // is the minimum inter-frame gap.
          state_d = IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset takes priority over everything, including a simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready_out  = ready_q;
  assign tx_out     = tx_q;
  assign parity_out = parity_q;
  assign busy       = busy_q;

endmodule : odd_parity_tx

// File: tb/tb_odd_parity_tx.sv
module tb_odd_parity_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, par_a, busy_a;
  logic       ready_b, tx_b, par_b, busy_b;

  always #5 clk = ~clk;

  odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_a),
    .valid_in   (valid_a),
    .ready_out  (ready_a),
    .tx_out     (tx_a),
    .parity_out (par_a),
    .busy       (busy_a)
  );

  odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_b),
    .valid_in   (valid_b),
    .ready_out  (ready_b),
    .tx_out     (tx_b),
    .parity_out (par_b),
    .busy       (busy_b)
  );

  logic [7:0]  sb[$];
  int          n_pass;
  int          n_total;
  logic        cap_tx   [0:199];
  logic        cap_busy [0:199];
  logic        cap_rdy  [0:199];
  logic [10:0] last_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic sample(input bit sel, input int i);
    cap_tx[i]   = sel ? tx_b    : tx_a;
    cap_busy[i] = sel ? busy_b  : busy_a;
    cap_rdy[i]  = sel ? ready_b : ready_a;
  endtask

  // Decode one captured frame, check every bit is held a full period, and
  // compare against the scoreboard head and the 9-bit odd-parity checker.
  task automatic decode_check(input string tag, input int base, input int cpb);
    logic [10:0] line;
    logic [10:0] exp_line;
    logic [7:0]  exp_d;
    logic        held;
    held = 1'b1;
    line = '0;
    for (int b = 0; b < 11; b++) begin
      line[b] = cap_tx[base + b*cpb];
      for (int j = 1; j < cpb; j++)
        if (cap_tx[base + b*cpb + j] !== line[b]) held = 1'b0;
    end
    last_line = line;
    check({tag, "_held"}, 32'(held), 32'd1);
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s_scoreboard: observed frame 0x%0h with no expected word queued", tag, line);
      return;
    end
    exp_d    = sb.pop_front();
    exp_line = {1'b1, ~^exp_d, exp_d, 1'b0};
    check({tag, "_line"}, 32'(line), 32'(exp_line));
    // Receiver-side checker: error when {parity,data} has even weight.
    check({tag, "_chk_err"}, 32'(~^line[9:1]), 32'd0);
  endtask

  // Called at a sampling point with the DUT idle; returns at the idle
  // sample following the frame, so consecutive calls are back-to-back.
  task automatic run_frame(input bit sel, input logic [7:0] d, input int cpb);
    int len;
    int nb;
    int nr;
    len = 11 * cpb;
    if (sel) begin data_b = d; valid_b = 1'b1; end
    else     begin data_a = d; valid_a = 1'b1; end
    sb.push_back(d);
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int i = 0; i <= len; i++) begin
      sample(sel, i);
      if (i < len) begin @(posedge clk); #1; end
    end
    nb = 0;
    nr = 0;
    for (int i = 0; i < len; i++) begin
      if (cap_busy[i] === 1'b1) nb++;
      if (cap_rdy[i] === 1'b0) nr++;
    end
    check("busy_cycles", 32'(nb), 32'(len));
    check("ready_low_cycles", 32'(nr), 32'(len));
    check("ready_after", 32'(cap_rdy[len]), 32'd1);
    check("busy_after", 32'(cap_busy[len]), 32'd0);
    check("tx_idle_after", 32'(cap_tx[len]), 32'd1);
    check("parity_out", 32'(sel ? par_b : par_a), 32'(~^d));
    decode_check("frame", 0, cpb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pv [5];
    logic       pe [5];
    int         cnt;
    pv = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h80};
    pe = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_ready_a", 32'(ready_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_parity_a", 32'(par_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_ready_b", 32'(ready_b), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_parity_b", 32'(par_b), 32'd0);

    // Reset together with valid: nothing accepted (0x00 would set parity 1)
    valid_a = 1'b1;
    data_a  = 8'h00;
    @(posedge clk); #1;
    rst     = 1'b0;
    valid_a = 1'b0;
    check("rstvld_ready", 32'(ready_a), 32'd1);
    check("rstvld_busy", 32'(busy_a), 32'd0);
    check("rstvld_parity", 32'(par_a), 32'd0);
    @(posedge clk); #1;
    check("rstvld_busy_next", 32'(busy_a), 32'd0);
    check("rstvld_tx_next", 32'(tx_a), 32'd1);

    // Single frame 0x01
    run_frame(1'b0, 8'h01, 4);
    check("seq_0x01", 32'(last_line), 32'(11'b10000000010));
    check("par_0x01", 32'(par_a), 32'd0);

    // Parity table, frames back-to-back with one idle cycle between
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0, pv[i], 4);
      check("par_table", 32'(par_a), 32'(pe[i]));
    end

    // valid held high, data changing every cycle: accepts at 0, 45, 90
    valid_a = 1'b1;
    for (int k = 0; k < 135; k++) begin
      data_a = 8'($urandom);
      if (k % 45 == 0) sb.push_back(data_a);
      @(posedge clk); #1;
      cap_tx[k]  = tx_a;
      cap_rdy[k] = ready_a;
    end
    valid_a = 1'b0;
    cnt = 0;
    for (int k = 0; k < 135; k++)
      if (cap_rdy[k] === 1'b1) cnt++;
    check("hs_ready_cycles", 32'(cnt), 32'd3);
    for (int f = 0; f < 3; f++) begin
      decode_check("hs_frame", f*45, 4);
      check("hs_gap_ready", 32'(cap_rdy[f*45 + 44]), 32'd1);
      check("hs_gap_tx", 32'(cap_tx[f*45 + 44]), 32'd1);
    end
    check("hs_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 of 0x5A (bit 3 = 1)
    data_a  = 8'h5A;
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    check("mid_bit3_tx", 32'(tx_a), 32'd1);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tx_a === 1'b1 && busy_a === 1'b0) cnt++;
    end
    check("mid_no_partial", 32'(cnt), 32'd6);
    run_frame(1'b0, 8'h3C, 4);
    check("par_0x3C", 32'(par_a), 32'd1);

    // One clock per bit
    run_frame(1'b1, 8'hC3, 1);
    check("seq_0xC3", 32'(last_line), 32'(11'b11110000110));

    // Exhaustive loopback sweep
    for (int v = 0; v < 256; v++)
      run_frame(1'b0, 8'(v), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_odd_parity_tx
